// File: rtl/i2c_transaction_sequencer_if.sv
// Command, buffer, status and engine-bus signals of the I2C transaction sequencer.
// Latency: none, signal bundle only.
// Backpressure: engine side is a single-outstanding request/ack pair; command side is fire-and-wait on done.
interface i2c_transaction_sequencer_if;
    // command port
    logic        cmd_start;
    logic        cmd_read;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [3:0]  cmd_len;
    // data buffer port
    logic        buf_we;
    logic [2:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_rdata;
    // status
    logic        busy;
    logic        done;
    logic [2:0]  err;
    // byte-level engine register bus
    logic        eng_request;
    logic        eng_write;
    logic        eng_address;
    logic [31:0] eng_wdata;
    logic        eng_ack;
    logic [31:0] eng_rdata;

    // sequencer side
    modport master (
        input  cmd_start, cmd_read, cmd_dev, cmd_reg, cmd_len,
        input  buf_we, buf_addr, buf_wdata,
        output buf_rdata, busy, done, err,
        output eng_request, eng_write, eng_address, eng_wdata,
        input  eng_ack, eng_rdata
    );

    // firmware + engine side
    modport slave (
        output cmd_start, cmd_read, cmd_dev, cmd_reg, cmd_len,
        output buf_we, buf_addr, buf_wdata,
        input  buf_rdata, busy, done, err,
        input  eng_request, eng_write, eng_address, eng_wdata,
        output eng_ack, eng_rdata
    );
endinterface

// File: rtl/i2c_transaction_sequencer.sv
// Runs a full register write / random read (0..BUF_DEPTH bytes) on the byte-level I2C engine.
// Latency: done one cycle after cmd_start for rejected commands, otherwise after the last STOP poll.
// Backpressure: one engine access outstanding, each waits for eng_ack; cmd_start and buf_we ignored while busy.
module i2c_transaction_sequencer #(
    parameter int BUF_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    i2c_transaction_sequencer_if.master       bus
);

    localparam int         IDX_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [3:0] MAX_LEN = 4'(BUF_DEPTH);

    // transaction step; every state between T_IDLE and T_DONE is one engine op
    typedef enum logic [3:0] {
        T_IDLE, T_START, T_ADDR_W, T_REG, T_DATA_W,
        T_RSTART, T_ADDR_R, T_DATA_R, T_STOP, T_DONE
    } top_t;

    // engine-op micro-sequence
    typedef enum logic [3:0] {
        OP_IDLE, OP_CTRL_REQ, OP_CTRL_WAIT, OP_DATA_REQ, OP_DATA_WAIT,
        OP_POLL_REQ, OP_POLL_WAIT, OP_RD_REQ, OP_RD_WAIT
    } op_t;

    top_t        r_top, w_top_nxt;
    op_t         r_op,  w_op_nxt;

    logic        r_read;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;
    logic [2:0]  r_err;
    logic [7:0]  r_buf [BUF_DEPTH];

    logic        w_busy;
    logic        w_accept;
    logic        w_invalid;
    logic        w_last;
    logic        w_is_ctrl;
    logic        w_is_rd;
    logic        w_mack;
    logic        w_sack;
    logic [7:0]  w_byte;
    logic [31:0] w_ctrl_word;
    logic        w_op_done;
    logic        w_rd_store;
    logic        w_err_set;
    logic [2:0]  w_err_code;
    logic        w_idx_inc;
    logic        w_eng_request;
    logic        w_eng_write;
    logic        w_eng_address;
    logic [31:0] w_eng_wdata;
    logic        w_unused;

    assign w_busy    = (r_top != T_IDLE) && (r_top != T_DONE);
    assign w_accept  = bus.cmd_start && !w_busy;
    assign w_invalid = (bus.cmd_len > MAX_LEN) || (bus.cmd_read && (bus.cmd_len == 4'd0));
    assign w_last    = (r_idx == (r_len - 4'd1));
    assign w_is_ctrl = (r_top == T_START) || (r_top == T_RSTART) || (r_top == T_STOP);
    assign w_is_rd   = (r_top == T_DATA_R);
    // master ACKs every received byte except the last one
    assign w_mack    = w_is_rd && !w_last;
    // slave ACK as reported by the final (not-busy) status poll
    assign w_sack    = bus.eng_rdata[3];
    assign w_unused  = ^{bus.eng_rdata[31:8], bus.eng_rdata[2:0]};

    // byte to put on the bus for the current step
    always_comb begin
        w_byte = 8'hFF;
        case (r_top)
            T_ADDR_W: w_byte = {r_dev, 1'b0};
            T_REG:    w_byte = r_reg;
            T_DATA_W: w_byte = r_buf[r_idx[IDX_W-1:0]];
            T_ADDR_R: w_byte = {r_dev, 1'b1};
            default:  w_byte = 8'hFF;
        endcase
    end

    // control word: START/STOP commands, or byte-op setup carrying mack
    always_comb begin
        w_ctrl_word = {29'd0, w_mack, 2'b00};
        case (r_top)
            T_START, T_RSTART: w_ctrl_word = 32'd1;
            T_STOP:            w_ctrl_word = 32'd2;
            default:           w_ctrl_word = {29'd0, w_mack, 2'b00};
        endcase
    end

    // top FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_top <= T_IDLE;
        else          r_top <= w_top_nxt;
    end

    // top FSM next state, NACK recording and byte index stepping
    always_comb begin
        w_top_nxt  = r_top;
        w_err_set  = 1'b0;
        w_err_code = 3'd0;
        w_idx_inc  = 1'b0;
        case (r_top)
            T_IDLE, T_DONE: begin
                w_top_nxt = T_IDLE;
                if (bus.cmd_start) w_top_nxt = w_invalid ? T_DONE : T_START;
            end
            T_START: if (w_op_done) w_top_nxt = T_ADDR_W;
            T_ADDR_W: if (w_op_done) begin
                if (!w_sack) begin
                    w_err_set = 1'b1; w_err_code = 3'd1; w_top_nxt = T_STOP;
                end else begin
                    w_top_nxt = T_REG;
                end
            end
            T_REG: if (w_op_done) begin
                if (!w_sack) begin
                    w_err_set = 1'b1; w_err_code = 3'd2; w_top_nxt = T_STOP;
                end else if (r_read) begin
                    w_top_nxt = T_RSTART;
                end else if (r_len == 4'd0) begin
                    w_top_nxt = T_STOP;
                end else begin
                    w_top_nxt = T_DATA_W;
                end
            end
            T_DATA_W: if (w_op_done) begin
                if (!w_sack) begin
                    w_err_set = 1'b1; w_err_code = 3'd3; w_top_nxt = T_STOP;
                end else if (w_last) begin
                    w_top_nxt = T_STOP;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            T_RSTART: if (w_op_done) w_top_nxt = T_ADDR_R;
            T_ADDR_R: if (w_op_done) begin
                if (!w_sack) begin
                    w_err_set = 1'b1; w_err_code = 3'd1; w_top_nxt = T_STOP;
                end else begin
                    w_top_nxt = T_DATA_R;
                end
            end
            T_DATA_R: if (w_op_done) begin
                if (w_last) w_top_nxt = T_STOP;
                else        w_idx_inc = 1'b1;
            end
            T_STOP: if (w_op_done) w_top_nxt = T_DONE;
            default: w_top_nxt = T_IDLE;
        endcase
    end

    // engine-op state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_op <= OP_IDLE;
        else          r_op <= w_op_nxt;
    end

    // engine-op sequencing: request, wait ack, poll until engine idle, optional data fetch
    always_comb begin
        w_op_nxt      = r_op;
        w_op_done     = 1'b0;
        w_rd_store    = 1'b0;
        w_eng_request = 1'b0;
        w_eng_write   = 1'b0;
        w_eng_address = 1'b0;
        w_eng_wdata   = 32'd0;
        case (r_op)
            OP_IDLE: if (w_busy) w_op_nxt = OP_CTRL_REQ;
            OP_CTRL_REQ: begin
                w_eng_request = 1'b1;
                w_eng_write   = 1'b1;
                w_eng_wdata   = w_ctrl_word;
                w_op_nxt      = OP_CTRL_WAIT;
            end
            OP_CTRL_WAIT: if (bus.eng_ack) w_op_nxt = w_is_ctrl ? OP_POLL_REQ : OP_DATA_REQ;
            OP_DATA_REQ: begin
                w_eng_request = 1'b1;
                w_eng_write   = 1'b1;
                w_eng_address = 1'b1;
                w_eng_wdata   = {24'd0, w_byte};
                w_op_nxt      = OP_DATA_WAIT;
            end
            OP_DATA_WAIT: if (bus.eng_ack) w_op_nxt = OP_POLL_REQ;
            OP_POLL_REQ: begin
                w_eng_request = 1'b1;
                w_op_nxt      = OP_POLL_WAIT;
            end
            OP_POLL_WAIT: if (bus.eng_ack) begin
                if (bus.eng_rdata[4]) begin
                    w_op_nxt = OP_POLL_REQ;
                end else if (w_is_rd) begin
                    w_op_nxt = OP_RD_REQ;
                end else begin
                    w_op_done = 1'b1;
                    w_op_nxt  = OP_IDLE;
                end
            end
            OP_RD_REQ: begin
                w_eng_request = 1'b1;
                w_eng_address = 1'b1;
                w_op_nxt      = OP_RD_WAIT;
            end
            OP_RD_WAIT: if (bus.eng_ack) begin
                w_rd_store = 1'b1;
                w_op_done  = 1'b1;
                w_op_nxt   = OP_IDLE;
            end
            default: w_op_nxt = OP_IDLE;
        endcase
    end

    // latch the command and reset the byte index on an accepted cmd_start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read <= 1'b0;
            r_dev  <= 7'd0;
            r_reg  <= 8'd0;
            r_len  <= 4'd0;
            r_idx  <= 4'd0;
        end else if (w_accept) begin
            r_read <= bus.cmd_read;
            r_dev  <= bus.cmd_dev;
            r_reg  <= bus.cmd_reg;
            r_len  <= bus.cmd_len;
            r_idx  <= 4'd0;
        end else if (w_idx_inc) begin
            r_idx  <= r_idx + 4'd1;
        end
    end

    // result code: cleared (or set to invalid-length) at accept, set on the first NACK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_err <= 3'd0;
        else if (w_accept)  r_err <= w_invalid ? 3'd4 : 3'd0;
        else if (w_err_set) r_err <= w_err_code;
    end

    // data buffer: firmware writes while idle, received bytes while reading
    always_ff @(posedge clk) begin
        if (bus.buf_we && !w_busy) r_buf[bus.buf_addr] <= bus.buf_wdata;
        else if (w_rd_store)       r_buf[r_idx[IDX_W-1:0]] <= bus.eng_rdata[7:0];
    end

    assign bus.buf_rdata   = r_buf[bus.buf_addr];
    assign bus.busy        = w_busy;
    assign bus.done        = (r_top == T_DONE);
    assign bus.err         = r_err;
    assign bus.eng_request = w_eng_request;
    assign bus.eng_write   = w_eng_write;
    assign bus.eng_address = w_eng_address;
    assign bus.eng_wdata   = w_eng_wdata;

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Directed bench for the I2C transaction sequencer with a behavioural byte-engine model.
// Latency: engine acks one cycle after each request and reports busy for two polls after every write.
// Backpressure: none beyond the engine request/ack pairing.
module tb_i2c_transaction_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    i2c_transaction_sequencer_if bus();

    i2c_transaction_sequencer #(.BUF_DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // engine model state; events: 1=START, 2=STOP, {mack,1,byte}=byte write
    int         ev_q[$];
    logic [7:0] rx_q[$];
    int         nack_idx  = -1;
    int         byte_k    = 0;
    int         poll_busy = 0;
    bit         pend_mack = 1'b0;
    bit         last_sack = 1'b1;
    int         req_cnt   = 0;

    always @(posedge clk) begin
        bus.eng_ack <= 1'b0;
        if (bus.eng_request) begin
            req_cnt++;
            bus.eng_ack   <= 1'b1;
            bus.eng_rdata <= 32'd0;
            if (bus.eng_write) begin
                poll_busy = 2;
                if (!bus.eng_address) begin
                    case (bus.eng_wdata[1:0])
                        2'd1:    ev_q.push_back(1);
                        2'd2:    ev_q.push_back(2);
                        default: pend_mack = bus.eng_wdata[2];
                    endcase
                end else begin
                    ev_q.push_back(int'({pend_mack, 1'b1, bus.eng_wdata[7:0]}));
                    last_sack = (byte_k != nack_idx);
                    byte_k++;
                end
            end else if (!bus.eng_address) begin
                if (poll_busy > 0) begin
                    poll_busy--;
                    bus.eng_rdata <= 32'h10;
                end else begin
                    bus.eng_rdata <= {28'd0, last_sack, 3'b000};
                end
            end else begin
                if (rx_q.size() > 0) bus.eng_rdata <= {24'd0, rx_q.pop_front()};
                else                 bus.eng_rdata <= 32'hEE;
            end
        end
    end

    // done pulses and engine-bus protocol violations
    int done_cnt   = 0;
    int proto_viol = 0;
    bit prev_req   = 1'b0;
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.eng_request && (prev_req || bus.eng_ack)) proto_viol++;
        prev_req = bus.eng_request;
    end

    function automatic string log_str();
        string s = "";
        foreach (ev_q[i]) s = {s, $sformatf("%0h ", ev_q[i])};
        return s;
    endfunction

    function automatic bit log_eq(input int exp[$]);
        if (exp.size() != ev_q.size()) return 1'b0;
        foreach (exp[i]) if (exp[i] != ev_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic eng_clear(input int nack);
        ev_q.delete();
        rx_q.delete();
        nack_idx  = nack;
        byte_k    = 0;
        poll_busy = 0;
        last_sack = 1'b1;
    endtask

    task automatic buf_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.buf_we    = 1'b1;
        bus.buf_addr  = a;
        bus.buf_wdata = d;
        @(negedge clk);
        bus.buf_we    = 1'b0;
    endtask

    task automatic issue(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len);
        @(negedge clk);
        bus.cmd_read  = rd;
        bus.cmd_dev   = dev;
        bus.cmd_reg   = rg;
        bus.cmd_len   = len;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.err !== 3'd0) begin errors++; $display("FAIL reset_err got %0d want 0", bus.err); end
        checks++; if (bus.eng_request !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.eng_request); end
        checks++; if ({bus.eng_write, bus.eng_address} !== 2'b00) begin errors++; $display("FAIL reset_wr_addr got %b want 00", {bus.eng_write, bus.eng_address}); end
        checks++; if (bus.eng_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", bus.eng_wdata); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int d0; bit ok;
        eng_clear(-1);
        buf_write(3'd0, 8'hA5);
        d0 = done_cnt;
        // buffer write in the same cycle as cmd_start must still land
        @(negedge clk);
        bus.cmd_read = 1'b0; bus.cmd_dev = 7'h50; bus.cmd_reg = 8'h10; bus.cmd_len = 4'd2;
        bus.cmd_start = 1'b1; bus.buf_we = 1'b1; bus.buf_addr = 3'd1; bus.buf_wdata = 8'h3C;
        @(negedge clk);
        bus.cmd_start = 1'b0; bus.buf_we = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL write_busy_rise got %b want 1", bus.busy); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_done_timeout got 0 want 1"); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL write_busy_at_done got %b want 0", bus.busy); end
        checks++; if (bus.err !== 3'd0) begin errors++; $display("FAIL write_err got %0d want 0", bus.err); end
        repeat (3) @(negedge clk);
        checks++; if (!log_eq('{1, 'h1A0, 'h110, 'h1A5, 'h13C, 2})) begin errors++; $display("FAIL write_events got %s want 1 1a0 110 1a5 13c 2", log_str()); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL write_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL write_protocol got %0d want 0", proto_viol); end
    endtask

    task automatic test_read();
        bit ok;
        logic [7:0] exp_rx [3];
        exp_rx = '{8'h12, 8'h34, 8'h56};
        eng_clear(-1);
        rx_q = '{8'h12, 8'h34, 8'h56};
        issue(1'b1, 7'h68, 8'h00, 4'd3);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_done_timeout got 0 want 1"); end
        checks++; if (bus.err !== 3'd0) begin errors++; $display("FAIL read_err got %0d want 0", bus.err); end
        repeat (3) @(negedge clk);
        checks++; if (!log_eq('{1, 'h1D0, 'h100, 1, 'h1D1, 'h3FF, 'h3FF, 'h1FF, 2})) begin errors++; $display("FAIL read_events got %s want 1 1d0 100 1 1d1 3ff 3ff 1ff 2", log_str()); end
        for (int i = 0; i < 3; i++) begin
            bus.buf_addr = 3'(i);
            #1;
            checks++; if (bus.buf_rdata !== exp_rx[i]) begin errors++; $display("FAIL read_buf%0d got %0h want %0h", i, bus.buf_rdata, exp_rx[i]); end
        end
    endtask

    task automatic test_addr_nack();
        int d0; bit ok;
        eng_clear(0);
        d0 = done_cnt;
        issue(1'b0, 7'h50, 8'h10, 4'd4);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL addr_nack_timeout got 0 want 1"); end
        checks++; if (bus.err !== 3'd1) begin errors++; $display("FAIL addr_nack_err got %0d want 1", bus.err); end
        repeat (3) @(negedge clk);
        checks++; if (!log_eq('{1, 'h1A0, 2})) begin errors++; $display("FAIL addr_nack_events got %s want 1 1a0 2", log_str()); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL addr_nack_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_data_nack();
        bit ok;
        buf_write(3'd0, 8'h11); buf_write(3'd1, 8'h22);
        buf_write(3'd2, 8'h33); buf_write(3'd3, 8'h44);
        eng_clear(3);
        issue(1'b0, 7'h50, 8'h10, 4'd4);
        wait_done(ok);
        checks++; if (bus.err !== 3'd3 || !ok) begin errors++; $display("FAIL data_nack_err got %0d want 3", bus.err); end
        repeat (3) @(negedge clk);
        checks++; if (!log_eq('{1, 'h1A0, 'h110, 'h111, 'h122, 2})) begin errors++; $display("FAIL data_nack_events got %s want 1 1a0 110 111 122 2", log_str()); end
    endtask

    task automatic test_reg_nack();
        bit ok;
        eng_clear(1);
        issue(1'b0, 7'h50, 8'h10, 4'd1);
        wait_done(ok);
        checks++; if (bus.err !== 3'd2 || !ok) begin errors++; $display("FAIL reg_nack_err got %0d want 2", bus.err); end
        repeat (3) @(negedge clk);
        checks++; if (!log_eq('{1, 'h1A0, 'h110, 2})) begin errors++; $display("FAIL reg_nack_events got %s want 1 1a0 110 2", log_str()); end
    endtask

    task automatic test_pointer_write();
        bit ok;
        eng_clear(-1);
        issue(1'b0, 7'h2A, 8'h7E, 4'd0);
        wait_done(ok);
        checks++; if (bus.err !== 3'd0 || !ok) begin errors++; $display("FAIL ptr_write_err got %0d want 0", bus.err); end
        repeat (3) @(negedge clk);
        checks++; if (!log_eq('{1, 'h154, 'h17E, 2})) begin errors++; $display("FAIL ptr_write_events got %s want 1 154 17e 2", log_str()); end
    endtask

    task automatic test_invalid();
        int r0;
        eng_clear(-1);
        r0 = req_cnt;
        issue(1'b0, 7'h50, 8'h10, 4'd9);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL len9_done got %b want 1", bus.done); end
        checks++; if (bus.err !== 3'd4) begin errors++; $display("FAIL len9_err got %0d want 4", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL len9_busy got %b want 0", bus.busy); end
        issue(1'b1, 7'h50, 8'h10, 4'd0);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL read0_done got %b want 1", bus.done); end
        checks++; if (bus.err !== 3'd4) begin errors++; $display("FAIL read0_err got %0d want 4", bus.err); end
        repeat (5) @(negedge clk);
        checks++; if (req_cnt != r0) begin errors++; $display("FAIL invalid_requests got %0d want 0", req_cnt - r0); end
    endtask

    task automatic test_busy_ignore();
        int d0; bit ok;
        buf_write(3'd0, 8'h77);
        eng_clear(-1);
        d0 = done_cnt;
        issue(1'b0, 7'h50, 8'h20, 4'd1);
        repeat (5) @(negedge clk);
        @(negedge clk);
        bus.cmd_read = 1'b1; bus.cmd_dev = 7'h11; bus.cmd_reg = 8'h99; bus.cmd_len = 4'd1;
        bus.cmd_start = 1'b1; bus.buf_we = 1'b1; bus.buf_addr = 3'd0; bus.buf_wdata = 8'h99;
        @(negedge clk);
        bus.cmd_start = 1'b0; bus.buf_we = 1'b0;
        wait_done(ok);
        repeat (5) @(negedge clk);
        checks++; if (!log_eq('{1, 'h1A0, 'h120, 'h177, 2})) begin errors++; $display("FAIL busy_ignore_events got %s want 1 1a0 120 177 2", log_str()); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_ignore_done_count got %0d want 1", done_cnt - d0); end
        bus.buf_addr = 3'd0;
        #1;
        checks++; if (bus.buf_rdata !== 8'h77) begin errors++; $display("FAIL busy_ignore_buf got %0h want 77", bus.buf_rdata); end
    endtask

    task automatic test_reset_mid();
        bit found; bit ok;
        buf_write(3'd0, 8'h11); buf_write(3'd1, 8'h22);
        eng_clear(-1);
        issue(1'b0, 7'h50, 8'h10, 4'd4);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (ev_q.size() == 4 && bus.eng_request && !bus.eng_write) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL reset_mid_reach got 0 want 1"); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", bus.busy); end
        checks++; if (bus.eng_request !== 1'b0) begin errors++; $display("FAIL reset_mid_req got %b want 0", bus.eng_request); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        eng_clear(-1);
        issue(1'b0, 7'h50, 8'h10, 4'd2);
        wait_done(ok);
        checks++; if (bus.err !== 3'd0 || !ok) begin errors++; $display("FAIL reset_mid_fresh_err got %0d want 0", bus.err); end
        repeat (3) @(negedge clk);
        checks++; if (!log_eq('{1, 'h1A0, 'h110, 'h111, 'h122, 2})) begin errors++; $display("FAIL reset_mid_fresh_events got %s want 1 1a0 110 111 122 2", log_str()); end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL protocol_total got %0d want 0", proto_viol); end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_read  = 1'b0;
        bus.cmd_dev   = 7'd0;
        bus.cmd_reg   = 8'd0;
        bus.cmd_len   = 4'd0;
        bus.buf_we    = 1'b0;
        bus.buf_addr  = 3'd0;
        bus.buf_wdata = 8'd0;
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_reg_nack();
        test_pointer_write();
        test_invalid();
        test_busy_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
